// File: rtl/decomp_writer.sv
// decomp_writer: buffers decompressed 16-bit words in a small FIFO and streams them to memory.
// Define DECOMP_WRITER_CHECKSUM_EN to add the XOR checksum port.
module decomp_writer #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [15:0]       din,
    input  logic              din_valid,
    output logic              fifo_full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_grant,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
`ifdef DECOMP_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [15:0]        fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [ADDR_W-1:0]  remain_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [15:0]        wdata_r;
    logic               mem_we_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               overflow_r;
    logic               fifo_full_r;

    logic               start_acc_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic [PTR_W-1:0]   rd_ptr_next_s;
    logic [PTR_W-1:0]   wr_ptr_next_s;
    logic [CNT_W-1:0]   count_next_s;
    logic [ADDR_W-1:0]  remain_next_s;
    logic [ADDR_W-1:0]  addr_next_s;
    logic [15:0]        head_next_s;
    logic               mem_we_next_s;
    logic               busy_next_s;
    logic               frame_done_next_s;
    logic               overflow_next_s;
    logic               fifo_full_next_s;
    logic [15:0]        wdata_next_s;

    // FIFO push/pop decisions and next values of the datapath counters
    always_comb begin
        start_acc_s = (state_r == ST_IDLE) && start;
        pop_s       = mem_we_r && mem_grant;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        if (din_valid && (state_r != ST_IDLE)) begin
            if ((state_r == ST_RUN) && (remain_r != ADDR_ZERO) && ((count_r != CNT_FULL) || pop_s)) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
        rd_ptr_next_s = rd_ptr_r + PTR_W'(pop_s);
        wr_ptr_next_s = wr_ptr_r + PTR_W'(push_s);
        count_next_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        if (start_acc_s) begin
            remain_next_s = word_count;
            addr_next_s   = base_addr;
        end else begin
            remain_next_s = remain_r - ADDR_W'(push_s);
            addr_next_s   = addr_r + ADDR_W'(pop_s);
        end
        // A word pushed into an otherwise-empty FIFO becomes the head without a storage read
        if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = din;
        end else begin
            head_next_s = fifo_mem_r[rd_ptr_next_s];
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = (word_count == ADDR_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (remain_next_s == ADDR_ZERO) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (count_next_s == CNT_ZERO) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Output values to be registered at the coming edge
    always_comb begin
        mem_we_next_s     = ((next_state_s == ST_RUN) || (next_state_s == ST_DRAIN)) &&
                            (count_next_s != CNT_ZERO);
        busy_next_s       = (next_state_s != ST_IDLE);
        frame_done_next_s = (state_r == ST_DONE);
        fifo_full_next_s  = (count_next_s == CNT_FULL);
        if (start_acc_s) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r | drop_s;
        end
        if (count_next_s != CNT_ZERO) begin
            wdata_next_s = head_next_s;
        end else begin
            wdata_next_s = wdata_r;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Pointers, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= CNT_ZERO;
            remain_r     <= ADDR_ZERO;
            addr_r       <= ADDR_ZERO;
            wdata_r      <= 16'h0000;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
            fifo_full_r  <= 1'b0;
        end else begin
            rd_ptr_r     <= rd_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            count_r      <= count_next_s;
            remain_r     <= remain_next_s;
            addr_r       <= addr_next_s;
            wdata_r      <= wdata_next_s;
            mem_we_r     <= mem_we_next_s;
            busy_r       <= busy_next_s;
            frame_done_r <= frame_done_next_s;
            overflow_r   <= overflow_next_s;
            fifo_full_r  <= fifo_full_next_s;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= din;
        end
    end

`ifdef DECOMP_WRITER_CHECKSUM_EN
    logic [15:0] checksum_r;

    // Running XOR of every word the memory accepted in this frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_r <= 16'h0000;
        end else if (start_acc_s) begin
            checksum_r <= 16'h0000;
        end else if (pop_s) begin
            checksum_r <= checksum_r ^ wdata_r;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`endif

    assign fifo_full  = fifo_full_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign mem_we     = mem_we_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_decomp_writer.sv
// Self-checking bench for decomp_writer: frame table with random data/handshake, queue-based
// reference model, and hand-written sequences for zero-length, overflow and mid-frame reset.
module tb_decomp_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic [15:0] word_count = 16'h0000;
    logic [15:0] din = 16'h0000;
    logic        din_valid = 1'b0;
    logic        fifo_full;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_grant = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        overflow;
`ifdef DECOMP_WRITER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    decomp_writer #(.ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .din        (din),
        .din_valid  (din_valid),
        .fifo_full  (fifo_full),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_grant  (mem_grant),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef DECOMP_WRITER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: words waiting for memory, next write address, words still to accept
    logic [15:0] m_q [$];
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_rem  = 16'h0000;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_ck   = 16'h0000;

    int          n_wr = 0;
    logic [15:0] last_addr = 16'h0000;

    typedef struct {
        logic [15:0] base;
        logic [15:0] count;
        int          valid_pct;
        int          grant_pct;
        logic [15:0] exp_last;
        int          exp_writes;
    } vec_t;

    vec_t vec [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_we"}, mem_we, 1'b0);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_done"}, frame_done, 1'b0);
        chk({nm, "_ovf"}, overflow, 1'b0);
        chk({nm, "_full"}, fifo_full, 1'b0);
        chk({nm, "_addr"}, mem_addr, 16'h0000);
        chk({nm, "_wdata"}, mem_wdata, 16'h0000);
    endtask

    // one clock with the given inputs; model advanced from the same inputs, outputs checked after
    task automatic cycle(input logic v, input logic [15:0] d, input logic g, input logic st);
        logic pop;
        logic push;
        int   occ;
        din_valid = v;
        din       = d;
        mem_grant = g;
        start     = st;
        if (mem_we && g) begin
            n_wr++;
            last_addr = mem_addr;
        end
        pop  = (m_q.size() > 0) && g;
        occ  = m_q.size() - (pop ? 1 : 0);
        push = v && (m_rem != 16'd0) && (occ < DEPTH);
        @(posedge clk);
        if (pop) begin
            m_ck ^= m_q[0];
            void'(m_q.pop_front());
            m_addr = m_addr + 16'd1;
        end
        if (push) begin
            m_q.push_back(d);
            m_rem = m_rem - 16'd1;
        end else if (v) begin
            m_ovf = 1'b1;
        end
        @(negedge clk);
        start     = 1'b0;
        din_valid = 1'b0;
        chk("mem_we", mem_we, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_q[0]);
        end
        chk("fifo_full", fifo_full, m_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, 1'b1);
        chk("frame_done_early", frame_done, 1'b0);
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        din_valid  = 1'b0;
        mem_grant  = 1'b0;
        @(posedge clk);
        m_addr = b;
        m_rem  = c;
        m_ovf  = 1'b0;
        m_ck   = 16'h0000;
        m_q.delete();
        n_wr   = 0;
        @(negedge clk);
        start      = 1'b0;
        base_addr  = 16'($urandom);
        word_count = 16'($urandom);
        chk("start_busy", busy, 1'b1);
        chk("start_we", mem_we, 1'b0);
        chk("start_ovf", overflow, 1'b0);
        chk("start_full", fifo_full, 1'b0);
        chk("start_addr", mem_addr, b);
        chk("start_done", frame_done, 1'b0);
    endtask

    // drain with grant held, then expect the DONE cycle followed by a single frame_done pulse
    task automatic finish_frame();
        int guard = 0;
        while (m_q.size() > 0 && guard < 100) begin
            cycle(1'b0, 16'h0000, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_bound", m_q.size(), 0);
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", frame_done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_we", mem_we, 1'b0);
`ifdef DECOMP_WRITER_CHECKSUM_EN
        chk("checksum", checksum, m_ck);
`endif
        @(posedge clk);
        @(negedge clk);
        chk("done_single", frame_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{16'h0100, 16'd3,  100, 100, 16'h0102, 3};
        vec[1] = '{16'hFFFF, 16'd2,  80,  70,  16'h0000, 2};
        vec[2] = '{16'h1234, 16'd10, 70,  50,  16'h123D, 10};
        vec[3] = '{16'hFFFC, 16'd8,  90,  30,  16'h0003, 8};
        vec[4] = '{16'h0000, 16'd1,  100, 100, 16'h0000, 1};
        vec[5] = '{16'h8000, 16'd20, 60,  60,  16'h8013, 20};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // three words at 0x0100 with grant held; a stray start mid-frame must be ignored
        do_start(16'h0100, 16'd3);
        cycle(1'b1, 16'hAAAA, 1'b1, 1'b0);
        cycle(1'b1, 16'h5555, 1'b1, 1'b1);
        cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        finish_frame();
        chk("basic_writes", n_wr, 3);
        chk("basic_last", last_addr, 16'h0102);
`ifdef DECOMP_WRITER_CHECKSUM_EN
        chk("basic_xor", checksum, 16'h0000);
`endif

        // zero-length frame: busy for one cycle, frame_done the cycle after, no writes
        do_start(16'h0040, 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("zero_done", frame_done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_we", mem_we, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("zero_single", frame_done, 1'b0);

        // five words against a stalled memory: fourth fills, fifth is dropped
        do_start(16'h0200, 16'd6);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        n_wr = 0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("ovf_released", n_wr, 4);
        cycle(1'b1, 16'h2000, 1'b1, 1'b0);
        cycle(1'b1, 16'h2001, 1'b1, 1'b0);
        finish_frame();

        // full FIFO with push and pop on the same edge: accepted, stays full, no overflow
        do_start(16'h0300, 16'd6);
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'h3004, 1'b1, 1'b0);
        chk("pp_full", fifo_full, 1'b1);
        chk("pp_ovf", overflow, 1'b0);
        cycle(1'b1, 16'h3005, 1'b1, 1'b0);
        finish_frame();
        chk("pp_writes", n_wr, 6);

        // table of frames with random data, random valid gaps and random grant stalls
        for (int t = 0; t < 6; t++) begin
            int guard = 0;
            do_start(vec[t].base, vec[t].count);
            while (m_rem != 16'd0 && guard < 2000) begin
                cycle(($urandom_range(99) < vec[t].valid_pct), 16'($urandom),
                      ($urandom_range(99) < vec[t].grant_pct), 1'b0);
                guard++;
            end
            chk("accept_bound", m_rem, 16'd0);
            finish_frame();
            chk("table_writes", n_wr, vec[t].exp_writes);
            chk("table_last", last_addr, vec[t].exp_last);
        end

        // reset after two of four words written, with overflow set beforehand
        do_start(16'h0500, 16'd4);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("mid_writes", n_wr, 2);
        chk("mid_ovf", overflow, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        m_q.delete();
        m_rem = 16'd0;
        m_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", frame_done, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        do_start(16'h0600, 16'd1);
        cycle(1'b1, 16'h6A6A, 1'b1, 1'b0);
        finish_frame();
        chk("post_rst_writes", n_wr, 1);
        chk("post_rst_last", last_addr, 16'h0600);
        chk("post_rst_ovf", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
